mcu_block_sequencer: RTL and testbench
======================================

# mcu_block_sequencer

Scheduler in front of the JPEG DC/AC run-length encoder. It tracks the current frame position (block within MCU, MCU column, MCU row) and, for every 8x8 block the DCT stage announces, emits one `stb` with the per-block tags the encoder latches: component number, first-of-component, color Huffman select, last-in-MCU, first block in frame and last MCU in frame. It also sequences frame start and frame end, and flags protocol errors.

## Interface

Clocking and reset: one clock; reset is asynchronous and active-high.

**Parameters**
- `MCU_W_BITS`, default 10: width of the MCU column and row counters.

**Ports**
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: compressor enable; low forces IDLE synchronously.
- `frame_start`  in  1: pulse; latches `mode`, `mcu_cols` and `mcu_rows`, and arms a new frame.
- `mode`  in  2: 0 = color 4:2:0 (6 blocks), 1 = mono (4 blocks), 2 = jp4diff (4 blocks), 3 = jp4 (4 blocks).
- `mcu_cols`  in  MCU_W_BITS: MCUs per row minus 1.
- `mcu_rows`  in  MCU_W_BITS: MCU rows minus 1.
- `block_rdy`  in  1: pulse; the DCT stage has a block for the encoder.
- `stb`  out  1: tag strobe to the encoder.
- `comp_number`  out  3: component number of the block.
- `comp_first`  out  1: first block of this component in the frame (encoder resets DC).
- `comp_color`  out  1: select chroma Huffman tables.
- `comp_lastinmb`  out  1: last block of the MCU.
- `first_block`  out  1: first block of the frame.
- `last_mcu`  out  1: block belongs to the last MCU of the frame.
- `busy`  out  1: state is RUN.
- `frame_done`  out  1: one-cycle pulse after the last block's `stb`.
- `err`  out  1: sticky; `block_rdy` arrived outside RUN.

## Operation

**Reset values.** All outputs are 0 and the state is IDLE.

**States**
- IDLE: `frame_start` with `en` high goes to RUN and clears the counters.
- RUN: each `block_rdy` issues one tagged `stb` and advances the counters. The `stb` for the last block of the last MCU goes to DONE.
- DONE: pulses `frame_done` for one cycle, then goes to IDLE.

**Block order per mode** (block index b within the MCU)
- Color: b = 0..5, components 0,0,0,0,1,2. `comp_color` = 1 for b = 4 and b = 5.
- Mono and jp4: b = 0..3, all component 0, `comp_color` = 0.
- Jp4diff: b = 0..3, components 0,1,2,3, `comp_color` = 0.

**Tag rules**
- `comp_first` = (MCU x = 0 and y = 0) and b is the first occurrence of its component in the MCU:
  - color: b = 0, 4, 5;
  - jp4diff: all b;
  - mono and jp4: b = 0.
- `comp_lastinmb` = (b = last index of the mode).
- `first_block` = (x = 0, y = 0, b = 0).
- `last_mcu` = (x = `mcu_cols`, y = `mcu_rows`).

**Counter advance**
- b increments and wraps to 0 at the last index.
- On a b wrap, x increments; at `mcu_cols` x wraps to 0 and y increments.
- `mode`, `mcu_cols` and `mcu_rows` are used only as latched at `frame_start`.

**Boundary conditions**
- `frame_start` in RUN or DONE: abort the current frame, clear the counters, stay in (or enter) RUN. No `frame_done` is produced for the aborted frame.
- `frame_start` and `block_rdy` in the same cycle: `frame_start` takes effect first, and the block is tagged as block 0 of the new frame.
- `block_rdy` in IDLE or DONE: no `stb` is issued and `err` is set. `err` is cleared only by `frame_start` or reset.
- `en` low: synchronous return to IDLE. `stb` and `frame_done` stay 0 while `en` is low. `err` is held.
- `mcu_cols` = `mcu_rows` = 0: a single-MCU frame. Every block has `last_mcu` = 1.
- `rst` asserted mid-frame: immediate return to the reset values.

## Timing

- Latency: `block_rdy` in cycle N gives `stb` plus valid tags in cycle N+1, all registered. Tags hold until the next `stb`.
- Throughput: one block per cycle is legal. The encoder requires at least 64 cycles between blocks; this block does not check that spacing.
- `frame_done` is asserted in the cycle after the final `stb`.
- `busy` rises the cycle after `frame_start` and falls in the `frame_done` cycle.

## Structure

- Shared package `jpeg_enc_pkg`:
  - mode encodings `MODE_COLOR`, `MODE_MONO`, `MODE_JP4DIFF`, `MODE_JP4`;
  - state enum;
  - block-tag struct {lasti, comp_lastinmb, comp_color, comp_first, comp_number[2:0]}, matching the encoder's tag order.
- One sub-module, `mcu_block_map`: a combinational lookup from (mode, b) to {comp_number, comp_color, first-occurrence, last-index}.
- Counters and the FSM stay in the top module.

## Test plan

1. Color mode, `mcu_cols` = 1, `mcu_rows` = 0, 12 `block_rdy` pulses:
   - `comp_number` runs 0,0,0,0,1,2 twice;
   - `comp_first` is set on blocks 0, 4, 5 only;
   - `comp_lastinmb` is set on blocks 5 and 11;
   - `last_mcu` is set on blocks 6-11;
   - `frame_done` comes one cycle after the 12th `stb`.
2. Jp4diff mode, 1x1 MCU: 4 strobes with components 0,1,2,3, all with `comp_first` = 1 and `comp_color` = 0; `first_block` is set only on the first strobe.
3. `frame_start` issued after block 3 of a mono 2x2 frame: the next `block_rdy` yields `first_block` = 1 and `comp_first` = 1; no `frame_done` is issued for the aborted frame.
4. `block_rdy` in IDLE: no `stb`, `err` = 1, and `err` clears on the next `frame_start`.
5. `frame_start` and `block_rdy` in the same cycle: `stb` in the next cycle carries `first_block` = 1.
6. `rst` pulsed mid-frame: all outputs read 0 in the next cycle, and `busy` = 0.

Source files
------------

// File: rtl/mcu_block_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_enc_pkg
// Shared definitions for the JPEG encoder front end: frame mode encodings,
// the block sequencer state type, the per-block tag layout the run-length
// encoder latches, and a helper giving the last block index of a mode.
// ---------------------------------------------------------------------------
package jpeg_enc_pkg;

    // Frame modes as presented on the sequencer mode input
    localparam logic [1:0] MODE_COLOR   = 2'd0;
    localparam logic [1:0] MODE_MONO    = 2'd1;
    localparam logic [1:0] MODE_JP4DIFF = 2'd2;
    localparam logic [1:0] MODE_JP4     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Field order matches the encoder's tag word; lasti marks the final
    // block of the frame.
    typedef struct packed {
        logic       lasti;
        logic       comp_lastinmb;
        logic       comp_color;
        logic       comp_first;
        logic [2:0] comp_number;
    } block_tag_t;

    // Color 4:2:0 carries six blocks per MCU, every other mode four.
    function automatic logic [2:0] lastBlockIndex(input logic [1:0] mode);
        return (mode == MODE_COLOR) ? 3'd5 : 3'd3;
    endfunction

endpackage

// File: rtl/mcu_block_sequencer_map.sv
// ---------------------------------------------------------------------------
// mcu_block_map
// Combinational lookup from (mode, block index within the MCU) to the
// static per-block attributes.
//   i_mode          in  2 : frame mode
//   i_block         in  3 : block index b inside the MCU
//   o_comp_number   out 3 : component the block belongs to
//   o_comp_color    out 1 : block uses the chroma Huffman tables
//   o_first_occ     out 1 : b is the first block of its component in the MCU
//   o_last_index    out 1 : b is the last block index of the mode
// ---------------------------------------------------------------------------
module mcu_block_map
    import jpeg_enc_pkg::*;
(
    input  logic [1:0] i_mode,
    input  logic [2:0] i_block,
    output logic [2:0] o_comp_number,
    output logic       o_comp_color,
    output logic       o_first_occ,
    output logic       o_last_index
);

    always_comb begin
        o_comp_number = 3'd0;
        o_comp_color  = 1'b0;
        o_first_occ   = 1'b0;
        o_last_index  = (i_block == lastBlockIndex(i_mode));
        case (i_mode)
            MODE_COLOR: begin
                // Four luma blocks, then Cb and Cr, one block each
                case (i_block)
                    3'd0: o_first_occ = 1'b1;
                    3'd4: begin
                        o_comp_number = 3'd1;
                        o_comp_color  = 1'b1;
                        o_first_occ   = 1'b1;
                    end
                    3'd5: begin
                        o_comp_number = 3'd2;
                        o_comp_color  = 1'b1;
                        o_first_occ   = 1'b1;
                    end
                    default: ;
                endcase
            end
            MODE_JP4DIFF: begin
                // Each Bayer sub-plane is its own component
                o_comp_number = i_block;
                o_first_occ   = 1'b1;
            end
            default: begin
                o_first_occ = (i_block == 3'd0);
            end
        endcase
    end

endmodule

// File: rtl/mcu_block_sequencer.sv
// ---------------------------------------------------------------------------
// mcu_block_sequencer
// Scheduler in front of the JPEG DC/AC run-length encoder. Tracks block /
// MCU column / MCU row of the current frame and, for every block announced
// by the DCT stage, emits one registered strobe with the block tags.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : compressor enable, low forces IDLE
//   frame_start         : latches mode/mcu_cols/mcu_rows and arms a frame
//   mode[1:0]           : color / mono / jp4diff / jp4
//   mcu_cols, mcu_rows  : MCUs per row minus 1, MCU rows minus 1
//   block_rdy           : DCT stage has a block
//   stb                 : tag strobe (tags hold until the next stb)
//   comp_number[2:0], comp_first, comp_color, comp_lastinmb,
//   first_block, last_mcu : per-block tags
//   busy                : frame in progress
//   frame_done          : pulse one cycle after the last block's stb
//   err                 : sticky, block_rdy outside RUN
// ---------------------------------------------------------------------------
module mcu_block_sequencer
    import jpeg_enc_pkg::*;
#(
    parameter int MCU_W_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  frame_start,
    input  logic [1:0]            mode,
    input  logic [MCU_W_BITS-1:0] mcu_cols,
    input  logic [MCU_W_BITS-1:0] mcu_rows,
    input  logic                  block_rdy,
    output logic                  stb,
    output logic [2:0]            comp_number,
    output logic                  comp_first,
    output logic                  comp_color,
    output logic                  comp_lastinmb,
    output logic                  first_block,
    output logic                  last_mcu,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    seq_state_t            r_state;
    logic [1:0]            r_mode;
    logic [MCU_W_BITS-1:0] r_cols;
    logic [MCU_W_BITS-1:0] r_rows;
    logic [2:0]            r_b;
    logic [MCU_W_BITS-1:0] r_x;
    logic [MCU_W_BITS-1:0] r_y;

    logic                  r_stb;
    logic [2:0]            r_comp_number;
    logic                  r_comp_first;
    logic                  r_comp_color;
    logic                  r_comp_lastinmb;
    logic                  r_first_block;
    logic                  r_last_mcu;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err;

    logic [1:0]            w_mode;
    logic [MCU_W_BITS-1:0] w_cols;
    logic [MCU_W_BITS-1:0] w_rows;
    logic [2:0]            w_b;
    logic [MCU_W_BITS-1:0] w_x;
    logic [MCU_W_BITS-1:0] w_y;
    logic [2:0]            w_map_number;
    logic                  w_map_color;
    logic                  w_map_first_occ;
    logic                  w_map_last_index;
    logic                  w_origin;
    logic                  w_last_mcu;
    logic                  w_first_block;
    block_tag_t            w_tag;
    logic [2:0]            w_b_next;
    logic [MCU_W_BITS-1:0] w_x_next;
    logic [MCU_W_BITS-1:0] w_y_next;
    logic                  w_accept;

    // A frame_start in the same cycle as block_rdy takes effect first, so the
    // tag lookup sees the incoming configuration and a cleared position.
    always_comb begin
        w_mode = frame_start ? mode     : r_mode;
        w_cols = frame_start ? mcu_cols : r_cols;
        w_rows = frame_start ? mcu_rows : r_rows;
        w_b    = frame_start ? 3'd0     : r_b;
        w_x    = frame_start ? '0       : r_x;
        w_y    = frame_start ? '0       : r_y;
    end

    mcu_block_map u_map (
        .i_mode        (w_mode),
        .i_block       (w_b),
        .o_comp_number (w_map_number),
        .o_comp_color  (w_map_color),
        .o_first_occ   (w_map_first_occ),
        .o_last_index  (w_map_last_index)
    );

    // Tags for the block being accepted this cycle. comp_first only applies
    // in the top-left MCU, where the encoder must reset its DC predictors.
    always_comb begin
        w_origin            = (w_x == '0) && (w_y == '0);
        w_last_mcu          = (w_x == w_cols) && (w_y == w_rows);
        w_first_block       = w_origin && (w_b == 3'd0);
        w_tag.comp_number   = w_map_number;
        w_tag.comp_color    = w_map_color;
        w_tag.comp_first    = w_origin && w_map_first_occ;
        w_tag.comp_lastinmb = w_map_last_index;
        w_tag.lasti         = w_map_last_index && w_last_mcu;
    end

    // Position after this block: b wraps at the mode's last index, carrying
    // into x, which wraps at mcu_cols and carries into y.
    always_comb begin
        w_b_next = w_b + 3'd1;
        w_x_next = w_x;
        w_y_next = w_y;
        if (w_map_last_index) begin
            w_b_next = 3'd0;
            if (w_x == w_cols) begin
                w_x_next = '0;
                w_y_next = w_y + 1'b1;
            end else begin
                w_x_next = w_x + 1'b1;
            end
        end
    end

    assign w_accept = block_rdy && (frame_start || (r_state == ST_RUN));

    // Sequencer FSM with counters and registered outputs. The frame_start
    // branch runs first so that a block accepted in the same cycle overrides
    // the cleared counters and, for a final block, the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_mode          <= MODE_COLOR;
            r_cols          <= '0;
            r_rows          <= '0;
            r_b             <= 3'd0;
            r_x             <= '0;
            r_y             <= '0;
            r_stb           <= 1'b0;
            r_comp_number   <= 3'd0;
            r_comp_first    <= 1'b0;
            r_comp_color    <= 1'b0;
            r_comp_lastinmb <= 1'b0;
            r_first_block   <= 1'b0;
            r_last_mcu      <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_err           <= 1'b0;
        end else if (!en) begin
            r_state      <= ST_IDLE;
            r_stb        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_stb        <= 1'b0;
            r_frame_done <= 1'b0;
            if (frame_start) begin
                r_mode  <= mode;
                r_cols  <= mcu_cols;
                r_rows  <= mcu_rows;
                r_b     <= 3'd0;
                r_x     <= '0;
                r_y     <= '0;
                r_err   <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
            end
            if (w_accept) begin
                r_stb           <= 1'b1;
                r_comp_number   <= w_tag.comp_number;
                r_comp_first    <= w_tag.comp_first;
                r_comp_color    <= w_tag.comp_color;
                r_comp_lastinmb <= w_tag.comp_lastinmb;
                r_first_block   <= w_first_block;
                r_last_mcu      <= w_last_mcu;
                r_b             <= w_b_next;
                r_x             <= w_x_next;
                r_y             <= w_y_next;
                if (w_tag.lasti) begin
                    r_state <= ST_DONE;
                end
            end else if (!frame_start) begin
                case (r_state)
                    ST_IDLE: begin
                        if (block_rdy) begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                        if (block_rdy) begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stb           = r_stb;
    assign comp_number   = r_comp_number;
    assign comp_first    = r_comp_first;
    assign comp_color    = r_comp_color;
    assign comp_lastinmb = r_comp_lastinmb;
    assign first_block   = r_first_block;
    assign last_mcu      = r_last_mcu;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign err           = r_err;

endmodule

// File: tb/tb_mcu_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mcu_block_sequencer
// Table-driven bench for mcu_block_sequencer. Each row holds one cycle of
// inputs plus the outputs expected right after the following clock edge,
// packed as {stb, comp_number[2:0], comp_first, comp_color, comp_lastinmb,
// first_block, last_mcu, busy, frame_done, err}. Reset is exercised by hand.
// ---------------------------------------------------------------------------
module tb_mcu_block_sequencer;

    localparam int W = 10;

    typedef struct {
        logic         fs;
        logic         br;
        logic         en;
        logic [1:0]   mode;
        logic [W-1:0] cols;
        logic [W-1:0] rows;
        logic [11:0]  exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         frameStart;
    logic [1:0]   mode;
    logic [W-1:0] mcuCols;
    logic [W-1:0] mcuRows;
    logic         blockRdy;
    logic         stb;
    logic [2:0]   compNumber;
    logic         compFirst;
    logic         compColor;
    logic         compLastInMb;
    logic         firstBlock;
    logic         lastMcu;
    logic         busy;
    logic         frameDone;
    logic         err;

    vec_t         vecs[$];
    logic [1:0]   cfgMode;
    logic [W-1:0] cfgCols;
    logic [W-1:0] cfgRows;
    int           assertCount;
    int           failCount;

    mcu_block_sequencer #(.MCU_W_BITS(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .frame_start   (frameStart),
        .mode          (mode),
        .mcu_cols      (mcuCols),
        .mcu_rows      (mcuRows),
        .block_rdy     (blockRdy),
        .stb           (stb),
        .comp_number   (compNumber),
        .comp_first    (compFirst),
        .comp_color    (compColor),
        .comp_lastinmb (compLastInMb),
        .first_block   (firstBlock),
        .last_mcu      (lastMcu),
        .busy          (busy),
        .frame_done    (frameDone),
        .err           (err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Appends one row using the configuration currently held in cfg*
    function automatic void addRow(input logic fs, input logic br, input logic e,
                                   input logic s, input logic [2:0] n,
                                   input logic f, input logic c, input logic l,
                                   input logic fb, input logic lm, input logic bsy,
                                   input logic dn, input logic er);
        vec_t v;
        v.fs   = fs;
        v.br   = br;
        v.en   = e;
        v.mode = cfgMode;
        v.cols = cfgCols;
        v.rows = cfgRows;
        v.exp  = {s, n, f, c, l, fb, lm, bsy, dn, er};
        vecs.push_back(v);
    endfunction

    // Compares the packed output word against the expected word
    task automatic checkOutput(input string name, input int idx, input logic [11:0] expWord);
        logic [11:0] act;
        act = {stb, compNumber, compFirst, compColor, compLastInMb,
               firstBlock, lastMcu, busy, frameDone, err};
        assertCount++;
        if (act !== expWord) begin
            failCount++;
            $display("[TB] FAIL %s[%0d] got %b want %b", name, idx, act, expWord);
        end
    endtask

    // Drives one row on the falling edge and checks just after the rising edge
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        frameStart = v.fs;
        blockRdy   = v.br;
        en         = v.en;
        mode       = v.mode;
        mcuCols    = v.cols;
        mcuRows    = v.rows;
        @(posedge clk);
        #1;
        checkOutput("vec", idx, v.exp);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        en          = 1'b1;
        frameStart  = 1'b0;
        blockRdy    = 1'b0;
        mode        = 2'd0;
        mcuCols     = '0;
        mcuRows     = '0;

        // Color, 2x1 MCUs; inputs changed after frame_start must be ignored
        cfgMode = 2'd0; cfgCols = 10'd1; cfgRows = 10'd0;
        addRow(1,0,1, 0,3'd0,0,0,0,0,0,1,0,0);
        cfgMode = 2'd1; cfgCols = 10'd0; cfgRows = 10'd0;
        addRow(0,1,1, 1,3'd0,1,0,0,1,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd1,1,1,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd2,1,1,1,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd1,0,1,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd2,0,1,1,0,1,1,0,0);
        addRow(0,0,1, 0,3'd2,0,1,1,0,1,0,1,0);
        addRow(0,0,1, 0,3'd2,0,1,1,0,1,0,0,0);
        // block_rdy in IDLE sets sticky err
        addRow(0,1,1, 0,3'd2,0,1,1,0,1,0,0,1);
        addRow(0,0,1, 0,3'd2,0,1,1,0,1,0,0,1);
        // Jp4diff single MCU; frame_start clears err
        cfgMode = 2'd2; cfgCols = 10'd0; cfgRows = 10'd0;
        addRow(1,0,1, 0,3'd2,0,1,1,0,1,1,0,0);
        addRow(0,1,1, 1,3'd0,1,0,0,1,1,1,0,0);
        addRow(0,0,1, 0,3'd0,1,0,0,1,1,1,0,0);
        addRow(0,1,1, 1,3'd1,1,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd2,1,0,0,0,1,1,0,0);
        addRow(0,1,1, 1,3'd3,1,0,1,0,1,1,0,0);
        // block_rdy in DONE: no stb, err set, frame_done still pulses
        addRow(0,1,1, 0,3'd3,1,0,1,0,1,0,1,1);
        addRow(0,0,1, 0,3'd3,1,0,1,0,1,0,0,1);
        // Mono 2x2, aborted by frame_start after block 3
        cfgMode = 2'd1; cfgCols = 10'd1; cfgRows = 10'd1;
        addRow(1,0,1, 0,3'd3,1,0,1,0,1,1,0,0);
        addRow(0,1,1, 1,3'd0,1,0,0,1,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,1,0,0,1,0,0);
        addRow(1,0,1, 0,3'd0,0,0,1,0,0,1,0,0);
        addRow(0,1,1, 1,3'd0,1,0,0,1,0,1,0,0);
        addRow(0,0,1, 0,3'd0,1,0,0,1,0,1,0,0);
        addRow(0,0,1, 0,3'd0,1,0,0,1,0,1,0,0);
        // frame_start with block_rdy, color single MCU
        cfgMode = 2'd0; cfgCols = 10'd0; cfgRows = 10'd0;
        addRow(1,1,1, 1,3'd0,1,0,0,1,1,1,0,0);
        // en low: IDLE, no stb, err held; block_rdy afterwards is an error
        addRow(0,1,0, 0,3'd0,1,0,0,1,1,0,0,0);
        addRow(0,1,0, 0,3'd0,1,0,0,1,1,0,0,0);
        addRow(0,1,1, 0,3'd0,1,0,0,1,1,0,0,1);
        // Jp4 single MCU, used below for the reset check
        cfgMode = 2'd3; cfgCols = 10'd0; cfgRows = 10'd0;
        addRow(1,0,1, 0,3'd0,1,0,0,1,1,1,0,0);
        addRow(0,1,1, 1,3'd0,1,0,0,1,1,1,0,0);
        addRow(0,1,1, 1,3'd0,0,0,0,0,1,1,0,0);

        // Reset values, checked while rst is still held
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 0, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_idle", 0, 12'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Mid-frame asynchronous reset clears everything before any edge
        @(negedge clk);
        frameStart = 1'b0;
        blockRdy   = 1'b1;
        rst        = 1'b1;
        #1;
        checkOutput("rst_async", 0, 12'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_held", 0, 12'd0);
        @(negedge clk);
        rst      = 1'b0;
        blockRdy = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_release", 0, 12'd0);
        // The sequencer is back in IDLE, so a block is a protocol error
        @(negedge clk);
        blockRdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_then_block", 0, 12'b0000_0000_0001);
        @(negedge clk);
        blockRdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
